// File: rtl/exp_lut_pkg.sv
// Shared constants and elaboration-time helpers for the exp LUT/interpolation unit.
// Contents:
//   DEF_*          default parameter values shared with the softmax top
//   exp_rom_entry  constant function giving one ROM sample of exp() in fixed point
//   lane_lsb       LSB position of a lane inside a packed multi-lane word
package exp_lut_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_FRAC_W     = 10;
    localparam int unsigned DEF_ADDR_W     = 8;
    localparam int unsigned DEF_RANGE_LOG2 = 3;
    localparam int unsigned DEF_LANES      = 4;
    localparam int unsigned DEF_INTERP     = 1;
    localparam int unsigned DEF_TAG_W      = 8;

    // Fraction bits of the internal fixed-point used while building the ROM.
    localparam int unsigned ROM_FX_W = 40;

    // ROM[k] = max(1, round(exp(-2^range_log2 + k*2^(shift-frac_w)) * 2^frac_w)).
    // exp(t) is summed as a Taylor series with t >= 0 (all terms positive, no
    // cancellation), then inverted with rounding: 2^frac_w / exp(t).
    function automatic int unsigned exp_rom_entry(
        input int unsigned k,
        input int unsigned frac_w,
        input int unsigned range_log2,
        input int unsigned addr_w
    );
        logic [127:0] t_fx;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] num;
        logic [127:0] q;
        int unsigned  shift;
        shift = range_log2 + frac_w - addr_w;
        if (k >= (32'd1 << addr_w)) begin
            return 32'd1 << frac_w;
        end
        t_fx = ((128'(1) << (range_log2 + frac_w)) - (128'(k) << shift)) << (ROM_FX_W - frac_w);
        term = 128'(1) << ROM_FX_W;
        sum  = term;
        for (int n = 1; n <= 64; n++) begin
            term = (term * t_fx) / (128'(n) << ROM_FX_W);
            sum  = sum + term;
        end
        num = 128'(1) << (frac_w + ROM_FX_W);
        q   = (num + (sum >> 1)) / sum;
        if (q == 128'(0)) begin
            q = 128'(1);
        end
        return 32'(q);
    endfunction

    // Bit offset of lane 'lane' in a word packed with 'w'-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/exp_interp_lane.sv
// One lane of the exp datapath: clamp/index, ROM read, interpolate.
// No handshake here; the top supplies per-stage load enables.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   en1, en2, en3   load enables for stage 1..3 registers
//   x               signed fixed-point input (already max-subtracted)
//   y               unsigned exp result (stage-3 register)
module exp_interp_lane
    import exp_lut_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FRAC_W     = DEF_FRAC_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned RANGE_LOG2 = DEF_RANGE_LOG2,
    parameter int unsigned INTERP     = DEF_INTERP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en1,
    input  logic              en2,
    input  logic              en3,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);

    localparam int unsigned SHIFT   = RANGE_LOG2 + FRAC_W - ADDR_W;
    localparam int unsigned OFF_W   = RANGE_LOG2 + FRAC_W + 1;
    localparam int unsigned SPAN    = 2 ** (RANGE_LOG2 + FRAC_W);
    localparam int unsigned ROM_TOP = 2 ** ADDR_W;
    localparam int unsigned ROM_N   = ROM_TOP + 1;
    localparam int unsigned PROD_W  = DATA_W + SHIFT;

    // Packs all ROM samples into one vector, entry k at bits [k*DATA_W +: DATA_W].
    function automatic logic [ROM_N*DATA_W-1:0] build_rom();
        logic [ROM_N*DATA_W-1:0] r;
        r = '0;
        for (int k = int'(ROM_N) - 1; k >= 0; k--) begin
            r = (r << DATA_W)
              | (ROM_N*DATA_W)'(DATA_W'(exp_rom_entry(32'(k), FRAC_W, RANGE_LOG2, ADDR_W)));
        end
        return r;
    endfunction

    localparam logic [ROM_N*DATA_W-1:0] ROM_BITS = build_rom();

    logic [DATA_W-1:0] rom [ROM_N];

    for (genvar k = 0; k < int'(ROM_N); k++) begin : g_rom
        assign rom[k] = ROM_BITS[k*DATA_W +: DATA_W];
    end

    // Stage 1: clamp to [XMIN, 0] and split the offset into ROM index and fraction.
    logic [DATA_W:0]   xs_c;
    logic [DATA_W:0]   sum_c;
    logic [OFF_W-1:0]  off_c;
    logic [ADDR_W:0]   addr_q;
    logic [SHIFT-1:0]  frac1_q;

    always_comb begin
        off_c = '0;
        xs_c  = {x[DATA_W-1], x};
        sum_c = xs_c + (DATA_W+1)'(SPAN);
        if (!x[DATA_W-1] && (x != '0)) begin
            off_c = OFF_W'(SPAN);
        end else if (sum_c[DATA_W]) begin
            off_c = '0;
        end else begin
            off_c = OFF_W'(sum_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            frac1_q <= '0;
        end else if (en1) begin
            addr_q  <= off_c[OFF_W-1:SHIFT];
            frac1_q <= off_c[SHIFT-1:0];
        end
    end

    // Stage 2: read both neighbouring samples; the last index pairs with itself.
    logic [ADDR_W:0]   addr_nx_c;
    logic [DATA_W-1:0] y0_q;
    logic [DATA_W-1:0] y1_q;
    logic [SHIFT-1:0]  frac2_q;

    always_comb begin
        addr_nx_c = addr_q;
        if (addr_q != (ADDR_W+1)'(ROM_TOP)) begin
            addr_nx_c = addr_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q    <= '0;
            y1_q    <= '0;
            frac2_q <= '0;
        end else if (en2) begin
            y0_q    <= rom[addr_q];
            y1_q    <= rom[addr_nx_c];
            frac2_q <= frac1_q;
        end
    end

    // Stage 3: y0 + round((y1-y0)*frac / 2^SHIFT); ROM is monotonic so y1 >= y0.
    logic [DATA_W-1:0] diff_c;
    logic [PROD_W-1:0] prod_c;
    logic [PROD_W-1:0] step_c;
    logic [DATA_W-1:0] res_c;
    logic [DATA_W-1:0] y_q;

    always_comb begin
        diff_c = y1_q - y0_q;
        prod_c = PROD_W'(diff_c) * PROD_W'(frac2_q);
        step_c = prod_c + PROD_W'(2 ** (SHIFT - 1));
        res_c  = y0_q;
        if (INTERP != 0) begin
            res_c = y0_q + DATA_W'(step_c >> SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else if (en3) begin
            y_q <= res_c;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/exp_lut_interp_pipe.sv
// Multi-lane exp(x) unit for the softmax datapath: 3-stage valid/ready pipeline
// around LANES copies of the ROM+interpolation lane, with a pass-through tag.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational from out_ready)
//   in_data             LANES signed words, lane i at [i*DATA_W +: DATA_W]
//   in_tag              sideband tag travelling with the beat
//   out_valid/out_ready output handshake
//   out_data            LANES unsigned exp results, same packing
//   out_tag             tag of the beat on out_data
module exp_lut_interp_pipe
    import exp_lut_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FRAC_W     = DEF_FRAC_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned RANGE_LOG2 = DEF_RANGE_LOG2,
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned INTERP     = DEF_INTERP,
    parameter int unsigned TAG_W      = DEF_TAG_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int SHIFT_CHK = int'(RANGE_LOG2) + int'(FRAC_W) - int'(ADDR_W);

    if (SHIFT_CHK < 1) begin : g_bad_shift
        $error("exp_lut_interp_pipe: RANGE_LOG2 + FRAC_W - ADDR_W must be at least 1");
    end

    // A stage advances when it is empty or its successor advances.
    logic v1_q, v2_q, v3_q;
    logic adv1_c, adv2_c;
    logic ld1_c, ld2_c, ld3_c;

    always_comb begin
        adv2_c = !v3_q || out_ready;
        adv1_c = !v2_q || adv2_c;
        ld1_c  = in_ready && in_valid;
        ld2_c  = adv1_c && v1_q;
        ld3_c  = adv2_c && v2_q;
    end

    assign in_ready  = !v1_q || adv1_c;
    assign out_valid = v3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (in_ready) v1_q <= in_valid;
            if (adv1_c)   v2_q <= v1_q;
            if (adv2_c)   v3_q <= v2_q;
        end
    end

    // Tag rides alongside the lane data registers.
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else begin
            if (ld1_c) tag1_q <= in_tag;
            if (ld2_c) tag2_q <= tag1_q;
            if (ld3_c) tag3_q <= tag2_q;
        end
    end

    assign out_tag = tag3_q;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        exp_interp_lane #(
            .DATA_W     (DATA_W),
            .FRAC_W     (FRAC_W),
            .ADDR_W     (ADDR_W),
            .RANGE_LOG2 (RANGE_LOG2),
            .INTERP     (INTERP)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en1   (ld1_c),
            .en2   (ld2_c),
            .en3   (ld3_c),
            .x     (in_data[lane_lsb(i, DATA_W) +: DATA_W]),
            .y     (out_data[lane_lsb(i, DATA_W) +: DATA_W])
        );
    end

endmodule

// File: tb/tb_exp_lut_interp_pipe.sv
// Bench for exp_lut_interp_pipe: directed vector table, backpressure stream,
// random valid/ready stream against a real-math reference, reset with beats in flight.
module tb_exp_lut_interp_pipe;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int TW    = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready, in_ready0;
    logic [LANES*DW-1:0]   in_data;
    logic [TW-1:0]         in_tag;
    logic                  out_valid, out_valid0;
    logic                  out_ready;
    logic [LANES*DW-1:0]   out_data, out_data0;
    logic [TW-1:0]         out_tag, out_tag0;

    always #5 clk = ~clk;

    exp_lut_interp_pipe #(.INTERP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    exp_lut_interp_pipe #(.INTERP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_tag(out_tag0)
    );

    int checks = 0;
    int errors = 0;
    int rom_m [257];

    typedef struct packed {
        logic [LANES-1:0][DW-1:0] x;
        logic [TW-1:0]            tag;
        logic [LANES-1:0][DW-1:0] e1;
        logic [LANES-1:0][DW-1:0] e0;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic logic [LANES*DW-1:0] mk(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    // Real-math reference ROM and the same clamp/index/interpolation arithmetic.
    task automatic init_rom();
        real v;
        int  r;
        for (int k = 0; k < 256; k++) begin
            v = $exp(-8.0 + real'(k) / 32.0) * 1024.0;
            r = $rtoi(v + 0.5);
            rom_m[k] = (r < 1) ? 1 : r;
        end
        rom_m[256] = 1024;
    endtask

    function automatic int ref_exp(input logic [DW-1:0] xin, input bit interp);
        int x, off, addr, frac, y0, y1;
        x = int'($signed(xin));
        if (x > 0) x = 0;
        if (x < -8192) x = -8192;
        off  = x + 8192;
        addr = off >> 5;
        frac = off & 31;
        y0   = rom_m[addr];
        y1   = rom_m[(addr == 256) ? 256 : addr + 1];
        if (interp) return y0 + (((y1 - y0) * frac + 16) >> 5);
        return y0;
    endfunction

    function automatic logic [DW-1:0] gen_lane();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'($urandom);
        if (r == 1) return 16'($urandom_range(0, 200));
        return 16'(0 - int'($urandom_range(0, 8300)));
    endfunction

    // One beat into an empty pipe; checks 3-cycle latency and hand-computed results.
    task automatic apply_vec(input string nm, input vec_t v);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = v.x;
        in_tag    = v.tag;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_tag   = 8'($urandom);
        chk({nm, " valid after 1 edge"}, int'(out_valid), 0);
        @(negedge clk);
        chk({nm, " valid after 2 edges"}, int'(out_valid), 0);
        @(negedge clk);
        chk({nm, " valid after 3 edges"}, int'(out_valid), 1);
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("%s interp lane%0d", nm, i), int'(out_data[i*DW +: DW]), int'(v.e1[i]));
            chk($sformatf("%s nointerp lane%0d", nm, i), int'(out_data0[i*DW +: DW]), int'(v.e0[i]));
        end
        chk({nm, " tag"}, int'(out_tag), int'(v.tag));
    endtask

    // Streams n beats; rnd=0 gives out_ready low on cycles 4..9, rnd=1 random toggling.
    task automatic run_stream(input string nm, input int n_beats, input bit rnd, input int max_cyc);
        logic [LANES*DW-1:0] qx [$];
        logic [TW-1:0]       qt [$];
        logic [LANES*DW-1:0] ex, prev_d;
        logic [TW-1:0]       et, prev_t;
        int  sent, got, occ, cyc;
        bit  prev_stall, in_hs, out_hs, saw_block, saw_hold;
        sent = 0; got = 0; occ = 0; cyc = 0;
        prev_stall = 1'b0; saw_block = 1'b0; saw_hold = 1'b0;
        prev_d = '0; prev_t = '0;
        while (got < n_beats && cyc < max_cyc) begin
            @(negedge clk);
            if (sent < n_beats && (!rnd || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                for (int i = 0; i < LANES; i++) in_data[i*DW +: DW] = gen_lane();
                in_tag = 8'(sent);
            end else begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                in_tag   = 8'($urandom);
            end
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 4 && cyc <= 9);
            #1;
            if (prev_stall) begin
                saw_hold = 1'b1;
                chk($sformatf("%s held valid cyc%0d", nm, cyc), int'(out_valid), 1);
                chk($sformatf("%s held data cyc%0d", nm, cyc), int'(out_data == prev_d), 1);
                chk($sformatf("%s held tag cyc%0d", nm, cyc), int'(out_tag), int'(prev_t));
            end
            chk($sformatf("%s in_ready cyc%0d occ%0d", nm, cyc, occ),
                int'(in_ready), int'((occ < 3) || out_ready));
            if (!in_ready) saw_block = 1'b1;
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_hs) begin
                if (qx.size() == 0) begin
                    chk($sformatf("%s spurious beat cyc%0d", nm, cyc), 1, 0);
                end else begin
                    ex = qx.pop_front();
                    et = qt.pop_front();
                    for (int i = 0; i < LANES; i++) begin
                        chk($sformatf("%s beat%0d lane%0d", nm, got, i),
                            int'(out_data[i*DW +: DW]), ref_exp(ex[i*DW +: DW], 1'b1));
                        chk($sformatf("%s beat%0d nointerp lane%0d", nm, got, i),
                            int'(out_data0[i*DW +: DW]), ref_exp(ex[i*DW +: DW], 1'b0));
                    end
                    chk($sformatf("%s beat%0d tag", nm, got), int'(out_tag), int'(et));
                end
                got++;
            end
            if (in_hs) begin
                qx.push_back(in_data);
                qt.push_back(in_tag);
                sent++;
            end
            occ        = occ + int'(in_hs) - int'(out_hs);
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_t     = out_tag;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({nm, " beats delivered within budget"}, got, n_beats);
        chk({nm, " scoreboard drained"}, qx.size(), 0);
        if (!rnd) begin
            chk({nm, " in_ready dropped when full"}, int'(saw_block), 1);
            chk({nm, " stall observed"}, int'(saw_hold), 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        init_rom();
        vecs[0].x  = mk(0, -1024, -8192, 5120);            vecs[0].tag = 8'h11;
        vecs[0].e1 = mk(1024, 377, 1, 1024);               vecs[0].e0  = mk(1024, 377, 1, 1024);
        vecs[1].x  = mk(-16, -16, -16, -16);               vecs[1].tag = 8'h22;
        vecs[1].e1 = mk(1008, 1008, 1008, 1008);           vecs[1].e0  = mk(992, 992, 992, 992);
        vecs[2].x  = mk(-2048, -512, -32, -1);             vecs[2].tag = 8'h33;
        vecs[2].e1 = mk(139, 621, 992, 1023);              vecs[2].e0  = mk(139, 621, 992, 992);
        vecs[3].x  = mk(-32768, 32767, -8160, -8193);      vecs[3].tag = 8'hC4;
        vecs[3].e1 = mk(1, 1024, 1, 1);                    vecs[3].e0  = mk(1, 1024, 1, 1);
        vecs[4].x  = mk(-1040, -1040, 0, -8192);           vecs[4].tag = 8'hFF;
        vecs[4].e1 = mk(371, 371, 1024, 1);                vecs[4].e0  = mk(365, 365, 1024, 1);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_data", int'(out_data == '0), 1);
        chk("reset out_tag", int'(out_tag), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) apply_vec($sformatf("vec%0d", v), vecs[v]);

        run_stream("bp", 10, 1'b0, 200);
        run_stream("rnd", 10000, 1'b1, 60000);

        // Fill the pipe with 3 beats under stall, then reset mid-flight.
        @(negedge clk);
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = vecs[b].x;
            in_tag   = vecs[b].tag;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre-reset pipe full", int'(out_valid), 1);
        chk("pre-reset in_ready low", int'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", int'(out_valid), 0);
        chk("mid reset in_ready", int'(in_ready), 1);
        chk("mid reset out_data", int'(out_data == '0), 1);
        chk("mid reset out_tag", int'(out_tag), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post reset no stale beat", int'(out_valid), 0);
        apply_vec("after reset", vecs[4]);
        @(negedge clk);
        chk("after reset drained", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_lut_interp_pipe.md
# exp_lut_interp_pipe

Parametrised, multi-lane exponential unit for the softmax datapath. It computes exp(x) for max-subtracted signed fixed-point inputs using a ROM of sampled points plus linear interpolation between adjacent points. It replaces the single-lane, free-running, nearest-entry LUT with a 3-stage valid/ready pipeline that supports backpressure. It sits between the max-subtract stage and the exp-sum accumulator, and it passes a sideband tag (row/column index) through unchanged.

## Interface
- DATA_W, default 16: signed input/output word width (S(DATA_W-FRAC_W-1).FRAC_W).
- FRAC_W, default 10: fraction bits on input and output.
- ADDR_W, default 8: ROM index bits; the ROM holds 2^ADDR_W + 1 sample points.
- RANGE_LOG2, default 3: the input domain is [-2^RANGE_LOG2, 0], i.e. [-8.0, 0.0].
- LANES, default 4: independent parallel lanes sharing one handshake.
- INTERP, default 1: 1 = linear interpolation; 0 = lower-sample lookup (legacy behaviour).
- TAG_W, default 8: sideband tag width.
- Derived SHIFT = RANGE_LOG2 + FRAC_W - ADDR_W (default 5). Elaboration must raise $error if SHIFT < 1.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept a beat.
- in_data, input, LANES*DATA_W: lane i occupies bits [i*DATA_W +: DATA_W]; signed.
- in_tag, input, TAG_W: sideband tag carried with the beat.
- out_valid, output, 1: result beat valid.
- out_ready, input, 1: downstream accepts the beat.
- out_data, output, LANES*DATA_W: exp results, unsigned magnitude, same lane packing as in_data.
- out_tag, output, TAG_W: the in_tag of the same beat.

## Operation
- Stage 1 (clamp/index), per lane:
  - Clamp x to [XMIN, 0], where XMIN = -(2^(RANGE_LOG2+FRAC_W)).
  - Positive inputs clamp to 0; inputs below XMIN clamp to XMIN.
  - off = x_clamped - XMIN, range 0..2^(RANGE_LOG2+FRAC_W).
  - addr = off >> SHIFT, width ADDR_W+1.
  - frac = off[SHIFT-1:0].
- Stage 2 (ROM read), per lane:
  - Register y0 = ROM[addr] and y1 = ROM[min(addr+1, 2^ADDR_W)], plus frac.
- Stage 3 (interpolate), per lane:
  - With INTERP=1: out = y0 + (((y1-y0)*frac + 2^(SHIFT-1)) >> SHIFT).
  - With INTERP=0: out = y0.
- ROM contents:
  - ROM[k] = max(1, round(exp(-2^RANGE_LOG2 + k*2^(SHIFT-FRAC_W)) * 2^FRAC_W)).
  - ROM[2^ADDR_W] = 2^FRAC_W (1.0).
  - The floor of 1 guarantees a nonzero softmax denominator.
- Arithmetic widths:
  - The ROM is monotonic, so y1-y0 >= 0; hold it in DATA_W bits unsigned.
  - Hold the product in DATA_W+SHIFT bits.
  - The result never exceeds 2^FRAC_W, so there is no output saturation.
- Lanes:
  - All lanes are computed identically and in lockstep.
  - The tag rides through the stage registers alongside the data.

## Timing
- Pipeline structure:
  - Three register stages, each with a valid bit v1..v3.
  - Latency is 3 cycles from an input handshake to out_valid when unstalled.
  - Throughput is 1 beat/cycle.
- Handshake rules:
  - A stage advances when it is empty or the stage after it is advancing.
  - in_ready = !v1 | adv1, where adv1 = !v2 | adv2, adv2 = !v3 | out_ready.
  - in_ready is combinational from out_ready; no other combinational in-to-out path exists.
  - out_valid = v3. out_data and out_tag are the stage-3 registers and are held stable while out_valid & !out_ready.
  - Registers of a stalled stage hold their values. An empty stage may load regardless of stall.
  - At most 3 beats are in flight. When full and out_ready=0, in_ready=0.
- Boundary cases:
  - Simultaneous in handshake and out handshake while full: both occur, and occupancy stays 3.
  - in_data is ignored when in_valid=0. in_data may change while in_ready=0.
- Reset values:
  - v1..v3 = 0, out_valid = 0, in_ready = 1 (combinationally, after reset).
  - out_data = 0, out_tag = 0.
  - Reset asserted mid-operation discards all in-flight beats with no partial outputs.

## Structure
- Package exp_lut_pkg holds:
  - the constant function exp_rom_entry(k, FRAC_W, RANGE_LOG2, ADDR_W), evaluated at elaboration to fill the ROM localparam;
  - the lane-slice helper;
  - the default parameter constants shared with the softmax top.
- Sub-module exp_interp_lane holds the per-lane stage 1-3 datapath (no handshake), instantiated LANES times.
- The handshake control (v1..v3, adv, tag) lives once in the top.

## Test plan
- Single beat with lanes = {0, -1024, -8192, +5120}: after 3 cycles, out_data = {1024, 377, 1, 1024}; out_tag echoed.
- Interpolation check:
  - With x = -16 (addr 255, frac 16) and INTERP=1: out = 992 + ((32*16+16)>>5) = 1008.
  - With INTERP=0: out = 992.
- Clamp extremes: x = -32768 -> 1; x = 32767 -> 1024.
- Backpressure:
  - Stimulus: stream 10 tagged beats, with out_ready low for cycles 4-9.
  - Required: in_ready falls after 3 accepted beats; out_data/out_tag are held stable while stalled; all 10 beats emerge in order with no loss or duplication.
- Random valid/ready toggling over 10k beats: results match a real-math reference model (same ROM and rounding) exactly, bit for bit.
- Reset asserted with 3 beats in flight: out_valid drops immediately; after release, the next beat returns after exactly 3 cycles with a correct value.
